// File: rtl/res_reader.sv
// Result SRAM drain: reads one ping/pong bank group row by row and streams 512-bit rows through a credit-limited FWFT FIFO.
// Optional macro RES_RD_STALL_CNT_EN adds a saturating downstream-stall counter output (stall_cnt).
module res_reader #(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int BANK_DEPTH = 2048
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         rd_req,
  input  logic         rd_bank,
  input  logic [11:0]  rd_len,
  output logic         rce0,
  output logic         rce1,
  output logic         rce2,
  output logic         rce3,
  output logic         rce4,
  output logic         rce5,
  output logic         rce6,
  output logic         rce7,
  output logic [14:0]  rraddr0,
  output logic [14:0]  rraddr1,
  output logic [14:0]  rraddr2,
  output logic [14:0]  rraddr3,
  output logic [14:0]  rraddr4,
  output logic [14:0]  rraddr5,
  output logic [14:0]  rraddr6,
  output logic [14:0]  rraddr7,
  input  logic [127:0] rrdata0,
  input  logic [127:0] rrdata1,
  input  logic [127:0] rrdata2,
  input  logic [127:0] rrdata3,
  input  logic [127:0] rrdata4,
  input  logic [127:0] rrdata5,
  input  logic [127:0] rrdata6,
  input  logic [127:0] rrdata7,
  output logic [511:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
`ifdef RES_RD_STALL_CNT_EN
  ,
  output logic [31:0]  stall_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t             r_state;
  logic               r_bank;
  logic [11:0]        r_len;
  logic [11:0]        r_issued;
  logic [11:0]        r_popped;
  logic [RD_LAT-1:0]  r_pipe_p0;
  logic               r_rce_ping;
  logic               r_rce_pong;
  logic [14:0]        r_addr_ping;
  logic [14:0]        r_addr_pong;
  logic               r_done;
  logic               r_busy;
  logic [511:0]       r_mem [FIFO_DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic [CW-1:0]      w_inflight;
  logic [CW:0]        w_credit_used;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_last_pop;
  logic [11:0]        w_len;
  logic [511:0]       w_push_data;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + {{(CW-1){1'b0}}, r_pipe_p0[i]};
    end
  end

  // Credits count both buffered rows and reads still in the SRAM pipe, so a push never finds the FIFO full.
  assign w_credit_used = {1'b0, r_count} + {1'b0, w_inflight};
  assign w_issue       = (r_state == S_READ) && (r_issued < r_len) &&
                         (w_credit_used < (CW+1)'(FIFO_DEPTH));
  assign w_push        = r_pipe_p0[RD_LAT-1];
  assign w_pop         = out_valid && out_ready;
  assign w_last_pop    = w_pop && ((r_popped + 12'd1) == r_len);
  assign w_len         = (rd_len > 12'(BANK_DEPTH)) ? 12'(BANK_DEPTH) : rd_len;
  assign w_push_data   = r_bank ? {rrdata7, rrdata6, rrdata5, rrdata4}
                                : {rrdata3, rrdata2, rrdata1, rrdata0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bank      <= 1'b0;
      r_len       <= '0;
      r_issued    <= '0;
      r_popped    <= '0;
      r_pipe_p0   <= '0;
      r_rce_ping  <= 1'b0;
      r_rce_pong  <= 1'b0;
      r_addr_ping <= '0;
      r_addr_pong <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else if (start) begin
      r_state    <= S_IDLE;
      r_issued   <= '0;
      r_popped   <= '0;
      r_pipe_p0  <= '0;
      r_rce_ping <= 1'b0;
      r_rce_pong <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_done     <= 1'b0;
      r_rce_ping <= 1'b0;
      r_rce_pong <= 1'b0;
      r_pipe_p0[0] <= w_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_p0[i] <= r_pipe_p0[i-1];
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      case (r_state)
        S_IDLE: begin
          if (rd_req) begin
            r_bank   <= rd_bank;
            r_len    <= w_len;
            r_issued <= '0;
            r_popped <= '0;
            if (w_len == 12'd0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_READ;
              r_busy  <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (w_issue) begin
            if (r_bank) begin
              r_rce_pong  <= 1'b1;
              r_addr_pong <= {r_issued[10:0], 4'b0000};
            end else begin
              r_rce_ping  <= 1'b1;
              r_addr_ping <= {r_issued[10:0], 4'b0000};
            end
            r_issued <= r_issued + 12'd1;
            if ((r_issued + 12'd1) == r_len) r_state <= S_DRAIN;
          end
          if (w_pop) r_popped <= r_popped + 12'd1;
        end
        S_DRAIN: begin
          if (w_pop) r_popped <= r_popped + 12'd1;
          if (w_last_pop) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Row storage carries no reset; pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

`ifdef RES_RD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (start || ((r_state == S_IDLE) && rd_req)) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign busy      = r_busy;
  assign done      = r_done;

  assign rce0 = r_rce_ping;
  assign rce1 = r_rce_ping;
  assign rce2 = r_rce_ping;
  assign rce3 = r_rce_ping;
  assign rce4 = r_rce_pong;
  assign rce5 = r_rce_pong;
  assign rce6 = r_rce_pong;
  assign rce7 = r_rce_pong;

  assign rraddr0 = r_addr_ping;
  assign rraddr1 = r_addr_ping;
  assign rraddr2 = r_addr_ping;
  assign rraddr3 = r_addr_ping;
  assign rraddr4 = r_addr_pong;
  assign rraddr5 = r_addr_pong;
  assign rraddr6 = r_addr_pong;
  assign rraddr7 = r_addr_pong;

endmodule

// File: tb/tb_res_reader.sv
// Directed bench for res_reader (RD_LAT=1, FIFO_DEPTH=4): SRAM model returns an address/bank-tagged pattern.
module tb_res_reader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         rd_req;
  logic         rd_bank;
  logic [11:0]  rd_len;
  logic         rce0, rce1, rce2, rce3, rce4, rce5, rce6, rce7;
  logic [14:0]  rraddr0, rraddr1, rraddr2, rraddr3, rraddr4, rraddr5, rraddr6, rraddr7;
  logic [127:0] rrdata0, rrdata1, rrdata2, rrdata3, rrdata4, rrdata5, rrdata6, rrdata7;
  logic [511:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;
`ifdef RES_RD_STALL_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_wrong  = 0;

  always #5 clk = ~clk;

  res_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_req(rd_req), .rd_bank(rd_bank), .rd_len(rd_len),
    .rce0(rce0), .rce1(rce1), .rce2(rce2), .rce3(rce3),
    .rce4(rce4), .rce5(rce5), .rce6(rce6), .rce7(rce7),
    .rraddr0(rraddr0), .rraddr1(rraddr1), .rraddr2(rraddr2), .rraddr3(rraddr3),
    .rraddr4(rraddr4), .rraddr5(rraddr5), .rraddr6(rraddr6), .rraddr7(rraddr7),
    .rrdata0(rrdata0), .rrdata1(rrdata1), .rrdata2(rrdata2), .rrdata3(rrdata3),
    .rrdata4(rrdata4), .rrdata5(rrdata5), .rrdata6(rrdata6), .rrdata7(rrdata7),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
`ifdef RES_RD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  function automatic logic [127:0] pat(input int k, input logic [14:0] a);
    return {16'hC0DE, 8'(k), 8'h5A, 32'(k) ^ 32'h1234_5678, 49'd0, a};
  endfunction

  function automatic logic [511:0] row_exp(input bit bank, input int row);
    logic [14:0] a;
    int b;
    a = {row[10:0], 4'b0000};
    b = bank ? 4 : 0;
    return {pat(b+3, a), pat(b+2, a), pat(b+1, a), pat(b, a)};
  endfunction

  // Read data is presented during the rce-high cycle, matching a one-cycle read latency.
  assign rrdata0 = pat(0, rraddr0);
  assign rrdata1 = pat(1, rraddr1);
  assign rrdata2 = pat(2, rraddr2);
  assign rrdata3 = pat(3, rraddr3);
  assign rrdata4 = pat(4, rraddr4);
  assign rrdata5 = pat(5, rraddr5);
  assign rrdata6 = pat(6, rraddr6);
  assign rrdata7 = pat(7, rraddr7);

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input bit bank, input int len);
    rd_req  = 1'b1;
    rd_bank = bank;
    rd_len  = 12'(len);
    step();
    rd_req  = 1'b0;
  endtask

  task automatic drain(input bit bank, input int start_row, input int max_cyc,
                       output int nrow, output int niss, output bit got_done,
                       output logic [14:0] first_a, output logic [14:0] last_a);
    nrow = 0; niss = 0; got_done = 1'b0; first_a = '1; last_a = '1;
    for (int c = 0; c < max_cyc && !got_done; c++) begin
      if (bank ? rce4 : rce0) begin
        if (niss == 0) first_a = bank ? rraddr4 : rraddr0;
        last_a = bank ? rraddr4 : rraddr0;
        niss++;
      end
      if (bank ? rce0 : rce4) n_wrong++;
      if (out_valid && out_ready) begin
        check("row_data", out_data, row_exp(bank, start_row + nrow));
        nrow++;
      end
      step();
      if (done) got_done = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrow, niss;
    bit got_done;
    logic [14:0] fa, la;

    rst_n = 1'b0; start = 1'b0; rd_req = 1'b0; rd_bank = 1'b0; rd_len = '0; out_ready = 1'b0;
    repeat (3) step();
    check("rst_valid", 512'(out_valid), 512'(0));
    check("rst_busy",  512'(busy),      512'(0));
    check("rst_done",  512'(done),      512'(0));
    check("rst_rce",   512'({rce7, rce6, rce5, rce4, rce3, rce2, rce1, rce0}), 512'(0));
    check("rst_addr",  512'(rraddr0),   512'(0));
    check("rst_data",  out_data,        512'(0));
    rst_n = 1'b1;
    step();

    // ping, 4 rows, downstream always ready
    out_ready = 1'b1;
    request(1'b0, 4);
    check("t1_busy0", 512'(busy), 512'(1));
    for (int k = 1; k <= 7; k++) begin
      step();
      check("t1_rce0", 512'(rce0), 512'(k <= 4));
      check("t1_rce3", 512'(rce3), 512'(k <= 4));
      check("t1_rce4", 512'(rce4), 512'(0));
      if (k <= 4) begin
        check("t1_addr0", 512'(rraddr0), 512'((k-1) * 16));
        check("t1_addr3", 512'(rraddr3), 512'((k-1) * 16));
      end
      check("t1_valid", 512'(out_valid), 512'(k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) check("t1_data", out_data, row_exp(1'b0, k-2));
      check("t1_done", 512'(done), 512'(k == 6));
      check("t1_busy", 512'(busy), 512'(k < 6));
    end

    // pong, 8 rows, backpressure limits issues to FIFO depth
    out_ready = 1'b0;
    n_wrong = 0;
    request(1'b1, 8);
    drain(1'b1, 0, 8, nrow, niss, got_done, fa, la);
    check("t2_stall_iss",  512'(niss), 512'(4));
    check("t2_stall_rows", 512'(nrow), 512'(0));
    check("t2_stall_last", 512'(la),   512'(15'h0030));
    check("t2_stall_vld",  512'(out_valid), 512'(1));
    out_ready = 1'b1;
    drain(1'b1, 0, 40, nrow, niss, got_done, fa, la);
    check("t2_iss",   512'(niss), 512'(4));
    check("t2_first", 512'(fa),   512'(15'h0040));
    check("t2_rows",  512'(nrow), 512'(8));
    check("t2_done",  512'(got_done), 512'(1));
    check("t2_wrong", 512'(n_wrong),  512'(0));
    check("t2_busy",  512'(busy), 512'(0));

    // zero-length request
    request(1'b0, 0);
    check("t3_done", 512'(done), 512'(1));
    check("t3_busy", 512'(busy), 512'(0));
    check("t3_rce",  512'(rce0), 512'(0));
    step();
    check("t3_done_clr", 512'(done), 512'(0));
    n_wrong = 0;
    drain(1'b0, 0, 6, nrow, niss, got_done, fa, la);
    check("t3_iss",   512'(niss), 512'(0));
    check("t3_nodone", 512'(got_done), 512'(0));

    // over-length request clamps to a full bank
    request(1'b0, 3000);
    drain(1'b0, 0, 2300, nrow, niss, got_done, fa, la);
    check("t4_iss",  512'(niss), 512'(2048));
    check("t4_rows", 512'(nrow), 512'(2048));
    check("t4_last", 512'(la),   512'(15'h7FF0));
    check("t4_hold", 512'(rraddr0), 512'(15'h7FF0));
    check("t4_done", 512'(got_done), 512'(1));

    // abort with 2 rows buffered and 1 in flight
    out_ready = 1'b0;
    request(1'b0, 8);
    repeat (3) step();
    check("t5_pre_vld", 512'(out_valid), 512'(1));
    check("t5_pre_rce", 512'(rce0), 512'(1));
    start = 1'b1;
    step();
    start = 1'b0;
    check("t5_vld",  512'(out_valid), 512'(0));
    check("t5_busy", 512'(busy), 512'(0));
    check("t5_rce",  512'(rce0), 512'(0));
    check("t5_done", 512'(done), 512'(0));
    for (int k = 0; k < 4; k++) begin
      step();
      check("t5_late_vld",  512'(out_valid), 512'(0));
      check("t5_late_done", 512'(done), 512'(0));
    end
    start = 1'b1;
    request(1'b0, 4);
    start = 1'b0;
    check("t5_prio_busy", 512'(busy), 512'(0));
    step();
    check("t5_prio_rce", 512'(rce0), 512'(0));
    out_ready = 1'b1;
    request(1'b0, 2);
    drain(1'b0, 0, 20, nrow, niss, got_done, fa, la);
    check("t5_first", 512'(fa),   512'(0));
    check("t5_rows",  512'(nrow), 512'(2));
    check("t5_done",  512'(got_done), 512'(1));

`ifdef RES_RD_STALL_CNT_EN
    out_ready = 1'b0;
    request(1'b0, 1);
    step();
    step();
    check("t6_vld",   512'(out_valid), 512'(1));
    check("t6_zero",  512'(stall_cnt), 512'(0));
    repeat (10) step();
    check("t6_stall", 512'(stall_cnt), 512'(10));
    out_ready = 1'b1;
    drain(1'b0, 0, 10, nrow, niss, got_done, fa, la);
    check("t6_done",  512'(got_done), 512'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/res_reader.md
Name: res_reader

Overview:
- Drains one completed result bank group (Bank 0-3 "ping" or Bank 4-7 "pong") from the result SRAM and streams it out as 512-bit rows with valid/ready handshake.
- Rows are stored as four 128-bit slices at address {row, 4'b0000}, Bank 0/4 = bits [127:0].
- Sits on the SRAM read ports, opposite the result writer; downstream is the post-processing/DMA path.
- Decouples fixed SRAM read latency from downstream backpressure with a credit-controlled output FIFO.

Parameters:
- RD_LAT, 1, SRAM read latency in cycles from rce-high cycle to rrdata valid (1..3)
- FIFO_DEPTH, 4, output buffer depth in rows (power of 2, >= RD_LAT+1)
- BANK_DEPTH, 2048, rows per bank group

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  synchronous abort/clear
- rd_req  in  1  read command pulse, accepted only in IDLE
- rd_bank  in  1  0 = ping (Bank 0-3), 1 = pong (Bank 4-7)
- rd_len  in  12  rows to read (0..2048)
- rce0..rce7  out  1 each  SRAM read enables (registered)
- rraddr0..rraddr7  out  15 each  SRAM read addresses (registered)
- rrdata0..rrdata7  in  128 each  SRAM read data
- out_data  out  512  row data {bank3,bank2,bank1,bank0} or {bank7..bank4}
- out_valid  out  1  row available
- out_ready  in  1  downstream accept
- busy  out  1  high in READ/DRAIN
- done  out  1  one-cycle pulse after last row transferred

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, counters 0, in-flight pipe cleared.
- States:
  - IDLE: on rd_req, latch rd_bank and len = min(rd_len, BANK_DEPTH), clear counters, go to READ. rd_req in READ/DRAIN is ignored.
  - READ: issue reads; after the last issue, go to DRAIN.
  - DRAIN: wait for in-flight returns and the FIFO to empty.
- rd_len = 0: go to IDLE with a done pulse on the next cycle; no rce asserted.
- Issue rule (evaluated each edge in READ): issue when issued < len and fifo_count + inflight < FIFO_DEPTH.
  - Issue drives the four rce of the selected group high for one cycle.
  - All four rraddr = {issued[10:0], 4'b0000}; unselected group rce stays 0; issued increments.
  - rraddr holds its last value when not issuing.
- Return: a shift pipe of RD_LAT valid bits tracks issues. At the edge ending cycle t+RD_LAT (t = rce-high cycle), the selected group's rrdata is pushed into the FIFO.
- FIFO is first-word-fall-through:
  - out_valid = !empty; out_data = head.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop leaves the count unchanged; the credit rule guarantees no overflow.
- Latency: rd_req sampled at edge 0 → rce high in the cycle after edge 1 → out_valid high after edge 1+RD_LAT (2 cycles for RD_LAT=1). With out_ready held high, throughput is 1 row/cycle.
- Completion: when popped == len, assert done for one cycle, deassert busy, return to IDLE on the same edge.
- start: priority over everything, including a same-cycle rd_req.
  - Go to IDLE, flush the FIFO, zero counters, clear the in-flight pipe (late rrdata discarded).
  - rce all 0; no done pulse.
- Address wrap is impossible because len is clamped to BANK_DEPTH; row 2047 reads address 15'h7FF0.

Optional Feature:
- Macro RES_RD_STALL_CNT_EN.
- Defined: adds output stall_cnt[31:0], incremented each cycle out_valid && !out_ready. It saturates at 32'hFFFFFFFF, clears on rd_req acceptance and on start, and resets to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- rd_req, rd_bank=0, rd_len=4, out_ready=1, RD_LAT=1 → rce0-3 high at rraddr 0x0000, 0x0010, 0x0020, 0x0030 in 4 consecutive cycles; rce4-7 stay 0; 4 rows out back-to-back, first out_valid 2 cycles after rd_req; done pulses once, busy falls.
- rd_bank=1, rd_len=8, out_ready=0 → exactly FIFO_DEPTH=4 reads issued, then no rce. Raise out_ready → remaining 4 issued; all 8 rows in order with pong data {rrdata7..rrdata4}.
- rd_len=0 → no rce ever; done pulses one cycle later.
- rd_len=3000 → exactly 2048 rows; last address 0x7FF0.
- start asserted mid-transfer with 2 rows in the FIFO and 1 in flight → out_valid 0 next cycle, no done, the late rrdata is not output. A new rd_req then restarts at address 0.
- RES_RD_STALL_CNT_EN defined, out_ready held low for 10 cycles with out_valid high → stall_cnt = 10.
